// File: rtl/bin_to_bcd_converter.sv
// Sequential signed-binary to 4-digit BCD converter using an iterative double-dabble engine.
// Optional build macro BCD_LEADING_BLANK_EN replaces leading zero digits with 4'hF.
module bin_to_bcd_converter #(
   parameter int unsigned IN_WIDTH = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic [IN_WIDTH-1:0] value_in,
   output logic                busy,
   output logic                done,
   output logic                overflow,
   output logic [3:0]          d3,
   output logic [3:0]          d2,
   output logic [3:0]          d1,
   output logic [3:0]          d0,
   output logic                is_negative
);

   localparam int unsigned CntW = $clog2(IN_WIDTH + 1);
`ifdef BCD_LEADING_BLANK_EN
   localparam logic [15:0] DigReset = 16'hFFF0;
`else
   localparam logic [15:0] DigReset = 16'h0000;
`endif

   typedef enum logic [1:0] {StIdle, StShift, StFinish} state_e;

   state_e              state_q, state_d;
   logic [IN_WIDTH-1:0] bin_q, bin_d;
   logic [15:0]         bcd_q, bcd_d;
   logic [CntW-1:0]     cnt_q, cnt_d;
   logic                neg_q, neg_d;
   logic                ovf_q, ovf_d;
   logic                nz_q, nz_d;
   logic                done_q, done_d;
   logic                overflow_q, overflow_d;
   logic                is_neg_q, is_neg_d;
   logic [15:0]         dig_q, dig_d;

   logic [IN_WIDTH-1:0] mag, mag_sat;
   logic [32:0]         mag_ext, limit;
   logic                clamp;
   logic [15:0]         bcd_adj, dig_fin;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= StIdle;
         bin_q      <= '0;
         bcd_q      <= '0;
         cnt_q      <= '0;
         neg_q      <= 1'b0;
         ovf_q      <= 1'b0;
         nz_q       <= 1'b0;
         done_q     <= 1'b0;
         overflow_q <= 1'b0;
         is_neg_q   <= 1'b0;
         dig_q      <= DigReset;
      end else begin
         state_q    <= state_d;
         bin_q      <= bin_d;
         bcd_q      <= bcd_d;
         cnt_q      <= cnt_d;
         neg_q      <= neg_d;
         ovf_q      <= ovf_d;
         nz_q       <= nz_d;
         done_q     <= done_d;
         overflow_q <= overflow_d;
         is_neg_q   <= is_neg_d;
         dig_q      <= dig_d;
      end
   end

   always_comb begin
      // Unsigned negate keeps the most negative input exact.
      mag     = value_in[IN_WIDTH-1] ? (~value_in + IN_WIDTH'(1)) : value_in;
      mag_ext = 33'(mag);
      limit   = value_in[IN_WIDTH-1] ? 33'd999 : 33'd9999;
      clamp   = (mag_ext > limit);
      mag_sat = clamp ? IN_WIDTH'(limit) : mag;

      for (int i = 0; i < 4; i++) begin
         bcd_adj[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5) ? (bcd_q[4*i +: 4] + 4'd3)
                                                         : bcd_q[4*i +: 4];
      end

      dig_fin = bcd_q;
`ifdef BCD_LEADING_BLANK_EN
      // For negative values d3 is left alone since the driver draws the minus there.
      if (neg_q && nz_q) begin
         if (bcd_q[11:8] == 4'd0) begin
            dig_fin[11:8] = 4'hF;
            if (bcd_q[7:4] == 4'd0) dig_fin[7:4] = 4'hF;
         end
      end else begin
         if (bcd_q[15:12] == 4'd0) begin
            dig_fin[15:12] = 4'hF;
            if (bcd_q[11:8] == 4'd0) begin
               dig_fin[11:8] = 4'hF;
               if (bcd_q[7:4] == 4'd0) dig_fin[7:4] = 4'hF;
            end
         end
      end
`endif

      state_d    = state_q;
      bin_d      = bin_q;
      bcd_d      = bcd_q;
      cnt_d      = cnt_q;
      neg_d      = neg_q;
      ovf_d      = ovf_q;
      nz_d       = nz_q;
      done_d     = 1'b0;
      overflow_d = overflow_q;
      is_neg_d   = is_neg_q;
      dig_d      = dig_q;

      case (state_q)
         StIdle: begin
            if (start) begin
               neg_d   = value_in[IN_WIDTH-1];
               ovf_d   = clamp;
               nz_d    = |mag;
               bin_d   = mag_sat;
               bcd_d   = '0;
               cnt_d   = CntW'(IN_WIDTH);
               state_d = StShift;
            end
         end
         StShift: begin
            bcd_d = {bcd_adj[14:0], bin_q[IN_WIDTH-1]};
            bin_d = bin_q << 1;
            cnt_d = cnt_q - CntW'(1);
            if (cnt_q == CntW'(1)) state_d = StFinish;
         end
         StFinish: begin
            dig_d      = dig_fin;
            overflow_d = ovf_q;
            is_neg_d   = neg_q & nz_q;
            done_d     = 1'b1;
            state_d    = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   assign busy        = (state_q != StIdle);
   assign done        = done_q;
   assign overflow    = overflow_q;
   assign is_negative = is_neg_q;
   assign d3          = dig_q[15:12];
   assign d2          = dig_q[11:8];
   assign d1          = dig_q[7:4];
   assign d0          = dig_q[3:0];

endmodule

// File: tb/tb_bin_to_bcd_converter.sv
// Directed, table-driven bench for bin_to_bcd_converter at the default width (16 bits).
module tb_bin_to_bcd_converter;

   logic        clk;
   logic        reset;
   logic        start;
   logic [15:0] value_in;
   logic        busy, done, overflow, is_negative;
   logic [3:0]  d3, d2, d1, d0;

   int passed = 0;
   int total  = 0;

   bin_to_bcd_converter #(.IN_WIDTH(16)) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .value_in    (value_in),
      .busy        (busy),
      .done        (done),
      .overflow    (overflow),
      .d3          (d3),
      .d2          (d2),
      .d1          (d1),
      .d0          (d0),
      .is_negative (is_negative)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] value;
      logic [15:0] exp_dig;
      logic        exp_neg;
      logic        exp_ovf;
   } vec_t;

   vec_t vecs[12];

   task automatic check_val(input string name, input logic [15:0] act, input logic [15:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   task automatic check_bit(input string name, input logic act, input logic exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %b, expected %b", name, act, exp);
   endtask

   // One full conversion; start sampled at edge 0, done expected after edge 17.
   task automatic run_conv(input string name, input logic [15:0] v, input logic [15:0] exp_dig,
                           input logic exp_neg, input logic exp_ovf);
      int lat;
      @(negedge clk);
      start    = 1'b1;
      value_in = v;
      @(posedge clk); #1;
      check_bit({name, " busy"}, busy, 1'b1);
      @(negedge clk);
      start = 1'b0;
      lat   = -1;
      for (int n = 1; n <= 40; n++) begin
         @(posedge clk); #1;
         if (done) begin
            lat = n;
            break;
         end
      end
      check_val({name, " latency"}, 16'(lat), 16'd17);
      check_val({name, " digits"}, {d3, d2, d1, d0}, exp_dig);
      check_bit({name, " is_negative"}, is_negative, exp_neg);
      check_bit({name, " overflow"}, overflow, exp_ovf);
      @(posedge clk); #1;
      check_bit({name, " done single"}, done, 1'b0);
   endtask

   initial begin
      logic [15:0] prev_dig;
      int          hold_bad, done_cnt, lat;

      vecs[0]  = '{16'd1234,      16'h1234, 1'b0, 1'b0};
      vecs[1]  = '{16'(-42),      16'h0042, 1'b1, 1'b0};
      vecs[2]  = '{16'd32767,     16'h9999, 1'b0, 1'b1};
      vecs[3]  = '{16'h8000,      16'h0999, 1'b1, 1'b1};
      vecs[4]  = '{16'd0,         16'h0000, 1'b0, 1'b0};
      vecs[5]  = '{16'd9999,      16'h9999, 1'b0, 1'b0};
      vecs[6]  = '{16'd10000,     16'h9999, 1'b0, 1'b1};
      vecs[7]  = '{16'(-999),     16'h0999, 1'b1, 1'b0};
      vecs[8]  = '{16'(-1000),    16'h0999, 1'b1, 1'b1};
      vecs[9]  = '{16'd1,         16'h0001, 1'b0, 1'b0};
      vecs[10] = '{16'd905,       16'h0905, 1'b0, 1'b0};
      vecs[11] = '{16'hFFFF,      16'h0001, 1'b1, 1'b0};

      reset    = 1'b1;
      start    = 1'b0;
      value_in = '0;
      repeat (2) @(posedge clk);
      #1;
      check_bit("reset busy", busy, 1'b0);
      check_bit("reset done", done, 1'b0);
      check_bit("reset overflow", overflow, 1'b0);
      check_bit("reset is_negative", is_negative, 1'b0);
      check_val("reset digits", {d3, d2, d1, d0}, 16'h0000);
      @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < 12; i++) begin
         run_conv($sformatf("vec%0d", i), vecs[i].value, vecs[i].exp_dig,
                  vecs[i].exp_neg, vecs[i].exp_ovf);
      end

      // Starts at edges 5 and 17 must be ignored; outputs hold until edge 17.
      prev_dig = {d3, d2, d1, d0};
      hold_bad = 0;
      done_cnt = 0;
      for (int n = 0; n <= 17; n++) begin
         @(negedge clk);
         start    = (n == 0) || (n == 5) || (n == 17);
         value_in = (n == 0) ? 16'd5678 : 16'd1111;
         @(posedge clk); #1;
         if (n >= 1 && n < 17) begin
            if ({d3, d2, d1, d0} !== prev_dig) hold_bad++;
            if (done) done_cnt++;
         end
         if (n == 16) check_bit("busy before finish", busy, 1'b1);
      end
      check_val("hold digits during conversion", 16'(hold_bad), 16'd0);
      check_val("no early done", 16'(done_cnt), 16'd0);
      check_bit("done at 17 despite start at 5", done, 1'b1);
      check_val("digits 5678", {d3, d2, d1, d0}, 16'h5678);
      // Start on the cycle after done is accepted.
      @(negedge clk);
      start    = 1'b1;
      value_in = 16'd4321;
      @(posedge clk); #1;
      check_bit("start after done accepted", busy, 1'b1);
      @(negedge clk);
      start = 1'b0;
      lat   = -1;
      for (int n = 1; n <= 40; n++) begin
         @(posedge clk); #1;
         if (done) begin
            lat = n;
            break;
         end
      end
      check_val("back-to-back latency", 16'(lat), 16'd17);
      check_val("back-to-back digits", {d3, d2, d1, d0}, 16'h4321);

      // Leave non-reset outputs so the asynchronous reset is observable.
      run_conv("pre-reset", 16'(-10000), 16'h0999, 1'b1, 1'b1);
      @(negedge clk);
      start    = 1'b1;
      value_in = 16'd9999;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      for (int n = 1; n <= 7; n++) @(posedge clk);
      #3;
      reset = 1'b1;
      #1;
      check_bit("async reset busy", busy, 1'b0);
      check_bit("async reset overflow", overflow, 1'b0);
      check_bit("async reset is_negative", is_negative, 1'b0);
      check_val("async reset digits", {d3, d2, d1, d0}, 16'h0000);
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset    = 1'b0;
      done_cnt = 0;
      for (int n = 0; n < 25; n++) begin
         @(posedge clk); #1;
         if (done || busy) done_cnt++;
      end
      check_val("aborted conversion silent", 16'(done_cnt), 16'd0);
      run_conv("after reset", 16'd7, 16'h0007, 1'b0, 1'b0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
